// File: rtl/lfsr_inj_pkg.sv
// Shared encodings for the LFSR error injector: mode codes and FSM states.
package lfsr_inj_pkg;

  localparam logic [1:0] OFF      = 2'd0;
  localparam logic [1:0] SINGLE   = 2'd1;
  localparam logic [1:0] PERIODIC = 2'd2;
  localparam logic [1:0] BURST    = 2'd3;

  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    INJECT = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr_error_injector.sv
// Forwards a valid/data beat stream, flipping one chosen bit on selected beats.
// Latency 1 cycle, all outputs registered; no backpressure, every beat is forwarded.
module lfsr_error_injector
  import lfsr_inj_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 16,
  localparam int POS_W   = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [1:0]          i_mode,
  input  logic                i_trigger,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [BURST_W-1:0]  i_burst_len,
  input  logic [POS_W-1:0]    i_bit_sel,
  input  logic                i_rotate,
  input  logic                i_clr_count,
  output logic                o_valid,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_err,
  output logic [CNT_W-1:0]    o_inj_count,
  output logic                o_busy
);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                trig_q, trig_d;
  logic [1:0]          mode_q, mode_d;

  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;

  logic                trig_edge;
  logic                mode_chg;
  logic                corrupt;
  logic [PERIOD_W-1:0] period_load;
  logic [BURST_W-1:0]  burst_load;
  logic [DATA_W-1:0]   flip_mask;

  assign trig_edge   = i_trigger & ~trig_q;
  assign mode_chg    = (i_mode != mode_q);
  assign period_load = (i_period == '0) ? PERIOD_W'(1) : i_period;
  assign burst_load  = ((i_mode == BURST) && (i_burst_len != '0)) ? i_burst_len : BURST_W'(1);
  // A mode change aborts the burst, so the beat in that cycle goes out clean.
  assign corrupt     = (state_q == INJECT) && i_valid && !mode_chg;
  assign flip_mask   = DATA_W'(1) << pos_q;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    pos_d        = pos_q;

    if (mode_chg) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      burst_cnt_d  = '0;
      pos_d        = i_bit_sel;
    end else begin
      case (state_q)
        IDLE: begin
          pos_d = i_bit_sel;
          if (i_mode == SINGLE) begin
            if (trig_edge) begin
              state_d     = INJECT;
              burst_cnt_d = BURST_W'(1);
            end
          end else if (i_mode != OFF) begin
            state_d      = COUNT;
            period_cnt_d = period_load;
          end
        end
        COUNT: begin
          if (i_valid) begin
            if (period_cnt_q <= PERIOD_W'(1)) begin
              period_cnt_d = '0;
              state_d      = INJECT;
              burst_cnt_d  = burst_load;
            end else begin
              period_cnt_d = period_cnt_q - PERIOD_W'(1);
            end
          end
        end
        INJECT: begin
          if (i_valid) begin
            // Position width is log2(DATA_W), so the increment wraps for free.
            if (i_rotate) begin
              pos_d = pos_q + POS_W'(1);
            end
            if (burst_cnt_q <= BURST_W'(1)) begin
              burst_cnt_d = '0;
              if (i_mode == SINGLE) begin
                state_d = IDLE;
              end else begin
                state_d      = COUNT;
                period_cnt_d = period_load;
              end
            end else begin
              burst_cnt_d = burst_cnt_q - BURST_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    valid_d = i_valid;
    err_d   = corrupt;
    data_d  = corrupt ? (i_data ^ flip_mask) : i_data;
    trig_d  = i_trigger;
    mode_d  = i_mode;
    busy_d  = (state_d != IDLE);
    cnt_d   = cnt_q;
    if (i_clr_count) begin
      cnt_d = corrupt ? CNT_W'(1) : '0;
    end else if (corrupt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      burst_cnt_q  <= '0;
      pos_q        <= i_bit_sel;
      trig_q       <= 1'b0;
      // Track the live mode so leaving reset is not mistaken for a mode change.
      mode_q       <= i_mode;
      valid_q      <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      pos_q        <= pos_d;
      trig_q       <= trig_d;
      mode_q       <= mode_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_err       = err_q;
  assign o_inj_count = cnt_q;
  assign o_busy      = busy_q;

endmodule

// File: doc/lfsr_error_injector.md
# lfsr_error_injector

Programmable error injector placed between the LFSR pattern generator and the sequence checker. It forwards the generator's valid/data stream with one cycle of latency and flips one selected bit on chosen beats. Modes are single-shot, periodic and burst. It replaces the fixed "flip bit 0 while corrupt is held" path so that lock loss and relock in the checker can be tested with deterministic, countable error patterns.

## Interface
- DATA_W, 8, data width; must be a power of two.
- PERIOD_W, 16, width of the clean-beat period.
- CNT_W, 16, width of the injected-error counter.
- clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  beat strobe from the generator.
- i_data  in  DATA_W  generator output.
- i_mode  in  2  0 = off, 1 = single-shot, 2 = periodic, 3 = burst.
- i_trigger  in  1  single-shot request; a rising edge is detected internally.
- i_period  in  PERIOD_W  number of clean valid beats between injections; 0 is treated as 1.
- i_burst_len  in  4  number of consecutive corrupted beats in burst mode; 0 is treated as 1.
- i_bit_sel  in  log2(DATA_W)  initial bit position to flip.
- i_rotate  in  1  when set, the bit position advances by 1 (mod DATA_W) after each corrupted beat.
- i_clr_count  in  1  clears o_inj_count.
- o_valid  out  1  registered copy of i_valid.
- o_data  out  DATA_W  forwarded data, possibly corrupted.
- o_err  out  1  high with o_data on every corrupted beat.
- o_inj_count  out  CNT_W  saturating count of corrupted beats.
- o_busy  out  1  high while state is COUNT or INJECT.

## Operation
- States:
  - IDLE: no injection.
  - COUNT: clean beats, period counter active.
  - INJECT: corrupting beats, burst counter active.
- Only cycles with i_valid=1 advance the counters and state. Cycles with i_valid=0 forward o_valid=0, set o_err=0 and hold all state.
- Corruption: o_data = i_data XOR (1 << pos). The other bits pass unchanged.
- IDLE, mode 0: stay in IDLE. pos is reloaded from i_bit_sel every cycle.
- IDLE, mode 1: a trigger rising edge sets burst_cnt=1 and moves to INJECT.
- IDLE, mode 2 or 3: load period_cnt = max(i_period, 1) and move to COUNT.
- COUNT: each valid beat is clean and decrements period_cnt. On the beat that brings it to 0, move to INJECT with burst_cnt = 1 (mode 2) or max(i_burst_len, 1) (mode 3).
- INJECT: each valid beat is corrupted. Then burst_cnt is decremented, o_inj_count is incremented (saturating at all-ones), and pos advances if i_rotate=1.
  - When burst_cnt reaches 0 in mode 1: go to IDLE.
  - When burst_cnt reaches 0 in mode 2 or 3: reload period_cnt and go to COUNT.
- i_period, i_burst_len and i_bit_sel are sampled only at load points. Changing them mid-operation takes effect at the next load.
- Any change of i_mode from its previous-cycle value forces IDLE on the next cycle and aborts any in-flight burst. A beat in that cycle passes clean.
- Trigger edges seen outside IDLE in mode 1 are ignored; they are not queued.
- i_clr_count and an injection in the same cycle: o_inj_count = 1.

## Timing
- Latency is 1 cycle from i_valid/i_data to o_valid/o_data/o_err. All outputs are registered.
- A trigger edge sampled in cycle t moves the state to INJECT at t+1. The first valid beat accepted at or after t+1 is corrupted.
- Reset values:
  - o_valid=0, o_data=0, o_err=0, o_inj_count=0, o_busy=0.
  - State IDLE, period_cnt=0, burst_cnt=0.
  - pos = i_bit_sel.
  - Trigger edge register = 0.
- Reset in the middle of a burst takes effect on the next edge. No further corrupted beat appears after reset is sampled.
- pos wraps from DATA_W-1 to 0.
- Steady-state injection rate is B corrupted beats per (P+B) valid beats.

## Structure
- Package lfsr_inj_pkg holds the mode encoding constants (OFF, SINGLE, PERIODIC, BURST) and the state encoding (IDLE, COUNT, INJECT).
- Single module with no sub-modules. The trigger edge detect and the mode-change detect are two flops inline.

## Test plan
- Mode 2, P=3, bit_sel=0, i_data=0xA5 held, i_valid=1 continuously:
  - beats 1-3 are 0xA5 with o_err=0;
  - beat 4 is 0xA4 with o_err=1;
  - the pattern repeats, and o_inj_count=2 after 8 beats.
- Mode 3, P=2, B=3, bit_sel=7, rotate=1, i_data=0x00: corrupted beats are 0x80, 0x01, 0x02, then 2 clean 0x00 beats, then 0x04.
- Mode 1 with i_data=0xFF, bit_sel=2 and i_valid=1 only every 3rd cycle: one trigger pulse corrupts exactly one beat (0xFB). A second pulse sent while in INJECT is ignored.
- Mode 3 with B=5: switch i_mode to 0 after 2 corrupted beats. No further o_err, state returns to IDLE, and o_inj_count=2.
- Assert i_rst during INJECT: the next cycle has o_valid=0, o_err=0 and o_inj_count=0. Raise i_clr_count together with an injection: the count reads 1.
- Mode 2 with P=0: injection occurs every 2nd valid beat, the same as P=1.
